// File: rtl/keypad_pin_entry.sv
// keypad_pin_entry: decodes keypad scanner hits on a 4x3 ATM keypad into
// key codes, accumulates a BCD PIN with backspace ('*') and submit ('#'),
// and hands the finished PIN to the processor with a valid/ack handshake.
// Optional feature macro: PIN_TIMEOUT_EN (inactivity clear during entry).
module keypad_pin_entry #(
  parameter int MAX_DIGITS     = 4,
  parameter int MIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    dataReady,
  input  logic [31:0]             foundRow,
  input  logic [31:0]             foundCol,
  input  logic                    pin_ack,
  output logic                    key_strobe,
  output logic [3:0]              key_code,
  output logic [3:0]              digit_count,
  output logic [4*MAX_DIGITS-1:0] pin_bcd,
  output logic                    pin_valid,
  output logic                    reject,
  output logic                    overflow,
  output logic                    timeout
);

  localparam int W = 4 * MAX_DIGITS;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);
  localparam logic [3:0] MIN_CNT = 4'(MIN_DIGITS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_BAD  = 4'd15;

  // Parameter legality, caught at elaboration.
  if (MAX_DIGITS < 1 || MAX_DIGITS > 8) begin : g_bad_max
    $error("keypad_pin_entry: MAX_DIGITS must be 1..8");
  end
  if (MIN_DIGITS < 1 || MIN_DIGITS > MAX_DIGITS) begin : g_bad_min
    $error("keypad_pin_entry: MIN_DIGITS must be 1..MAX_DIGITS");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("keypad_pin_entry: TIMEOUT_CYCLES must be at least 1");
  end

  // Map a scanner row/column pair to a key code. Full 32-bit compares so a
  // wild index in the upper bits can never alias onto a real key.
  function automatic logic [3:0] decode_key(input logic [31:0] row,
                                            input logic [31:0] col);
    logic [3:0] code;
    if (row < 32'd3 && col < 32'd3) begin
      code = row[3:0] * 4'd3 + col[3:0] + 4'd1;
    end else if (row == 32'd3) begin
      if (col == 32'd0) begin
        code = KEY_STAR;
      end else if (col == 32'd1) begin
        code = 4'd0;
      end else if (col == 32'd2) begin
        code = KEY_HASH;
      end else begin
        code = KEY_BAD;
      end
    end else begin
      code = KEY_BAD;
    end
    return code;
  endfunction

  // Synchronizer / edge detector / captured key
  logic       sync1_q, sync2_q, prev_q;
  logic       rise_s;
  logic       pend_q;
  logic [3:0] pend_code_q;

  // FSM and datapath
  logic [1:0]   state_q, state_d;
  logic [W-1:0] buf_q, buf_d;
  logic [3:0]   count_q, count_d;
  logic         strobe_q, strobe_d;
  logic [3:0]   code_q, code_d;
  logic         valid_q, valid_d;
  logic         reject_q, reject_d;
  logic         overflow_q, overflow_d;

  // View of the buffer after any inactivity clear in this cycle
  logic         tmo_fire_s;
  logic [1:0]   base_state_s;
  logic [W-1:0] base_buf_s;
  logic [3:0]   base_cnt_s;
  logic [W-1:0] digit_ext_s;

  assign rise_s = sync2_q & ~prev_q;

  // Bring the asynchronous dataReady level into the clock domain and keep
  // the previous synced value for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= dataReady;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Sample and decode row/column only on a synced rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q      <= 1'b0;
      pend_code_q <= 4'd0;
    end else begin
      pend_q <= rise_s;
      if (rise_s) begin
        pend_code_q <= decode_key(foundRow, foundCol);
      end else begin
        pend_code_q <= pend_code_q;
      end
    end
  end

`ifdef PIN_TIMEOUT_EN
  localparam logic [31:0] TMO_RELOAD = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q;

  // The counter reaches zero exactly TIMEOUT_CYCLES clocks after the last strobe.
  assign tmo_fire_s = (state_q == ST_ENTRY) && (tmo_cnt_q == 32'd0);

  // Reload on every strobe, count down only while entering digits, hold otherwise.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (pend_q) begin
      tmo_cnt_d = TMO_RELOAD;
    end else if (state_q == ST_ENTRY && tmo_cnt_q != 32'd0) begin
      tmo_cnt_d = tmo_cnt_q - 32'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Inactivity counter and its one-cycle timeout pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_q <= TMO_RELOAD;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= tmo_fire_s;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_fire_s = 1'b0;
  assign timeout    = 1'b0;
`endif

  // A key arriving in the timeout cycle is applied to the already-cleared buffer.
  always_comb begin
    if (tmo_fire_s) begin
      base_state_s = ST_IDLE;
      base_buf_s   = '0;
      base_cnt_s   = 4'd0;
    end else begin
      base_state_s = state_q;
      base_buf_s   = buf_q;
      base_cnt_s   = count_q;
    end
  end

  // Zero-extend the pending digit to buffer width (works for a 1-digit buffer too).
  always_comb begin
    digit_ext_s      = '0;
    digit_ext_s[3:0] = pend_code_q;
  end

  // Next-state logic: handshake in READY, key handling in IDLE/ENTRY.
  always_comb begin
    state_d    = base_state_s;
    buf_d      = base_buf_s;
    count_d    = base_cnt_s;
    valid_d    = valid_q;
    strobe_d   = pend_q;
    code_d     = pend_q ? pend_code_q : code_q;
    reject_d   = 1'b0;
    overflow_d = 1'b0;

    if (state_q == ST_READY) begin
      // Keys are strobed but otherwise ignored; ack wins over any key.
      if (pin_ack) begin
        valid_d = 1'b0;
        buf_d   = '0;
        count_d = 4'd0;
        state_d = ST_IDLE;
      end else begin
        valid_d = 1'b1;
      end
    end else if (pend_q) begin
      case (pend_code_q)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
          if (base_cnt_s < MAX_CNT) begin
            buf_d   = (base_buf_s << 3'd4) | digit_ext_s;
            count_d = base_cnt_s + 4'd1;
            state_d = ST_ENTRY;
          end else begin
            overflow_d = 1'b1;
          end
        end
        KEY_STAR: begin
          if (base_cnt_s != 4'd0) begin
            buf_d   = base_buf_s >> 3'd4;
            count_d = base_cnt_s - 4'd1;
            state_d = (base_cnt_s == 4'd1) ? ST_IDLE : ST_ENTRY;
          end else begin
            count_d = 4'd0;
          end
        end
        KEY_HASH: begin
          if (base_cnt_s >= MIN_CNT) begin
            state_d = ST_READY;
            valid_d = 1'b1;
          end else begin
            reject_d = 1'b1;
            buf_d    = '0;
            count_d  = 4'd0;
            state_d  = ST_IDLE;
          end
        end
        default: begin
          reject_d = 1'b1;
        end
      endcase
    end else begin
      valid_d = 1'b0;
    end
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      count_q    <= 4'd0;
      strobe_q   <= 1'b0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      reject_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      strobe_q   <= strobe_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      reject_q   <= reject_d;
      overflow_q <= overflow_d;
    end
  end

  assign key_strobe  = strobe_q;
  assign key_code    = code_q;
  assign digit_count = count_q;
  assign pin_bcd     = buf_q;
  assign pin_valid   = valid_q;
  assign reject      = reject_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Testbench for keypad_pin_entry: directed scenarios plus randomized key
// traffic checked against a queue-based PIN model. Build with
// +define+PIN_TIMEOUT_EN to exercise the inactivity timeout.
module tb_keypad_pin_entry;

  localparam int MAXD = 4;
  localparam int MIND = 4;
  localparam int TMO  = 20;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             dataReady = 1'b0;
  logic [31:0]      foundRow = 32'd0;
  logic [31:0]      foundCol = 32'd0;
  logic             pin_ack = 1'b0;
  logic             key_strobe;
  logic [3:0]       key_code;
  logic [3:0]       digit_count;
  logic [4*MAXD-1:0] pin_bcd;
  logic             pin_valid, reject, overflow, timeout;

  keypad_pin_entry #(.MAX_DIGITS(MAXD), .MIN_DIGITS(MIND), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .dataReady(dataReady), .foundRow(foundRow),
    .foundCol(foundCol), .pin_ack(pin_ack), .key_strobe(key_strobe),
    .key_code(key_code), .digit_count(digit_count), .pin_bcd(pin_bcd),
    .pin_valid(pin_valid), .reject(reject), .overflow(overflow), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Cycle counter and pulse monitors (sampled on the falling edge)
  int cyc = 0;
  int strb_cnt = 0;
  int tmo_cnt = 0;
  int last_strobe_cyc = 0;
  int last_tmo_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (key_strobe === 1'b1) begin
      strb_cnt        <= strb_cnt + 1;
      last_strobe_cyc <= cyc;
    end
    if (timeout === 1'b1) begin
      tmo_cnt      <= tmo_cnt + 1;
      last_tmo_cyc <= cyc;
    end
  end

  // Reference model: digits in entry order, plus the submitted flag
  int q[$];
  bit m_ready = 1'b0;

  function automatic int model_code(input int unsigned row, input int unsigned col);
    if (row <= 2 && col <= 2) return int'(row * 3 + col + 1);
    if (row == 3 && col == 0) return 10;
    if (row == 3 && col == 1) return 0;
    if (row == 3 && col == 2) return 11;
    return 15;
  endfunction

  function automatic logic [31:0] model_bcd();
    logic [31:0] b = 32'd0;
    foreach (q[i]) b = (b << 4) | 32'(q[i]);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete key press: assert, verify latency and result, release.
  task automatic press(input int unsigned row, input int unsigned col);
    int  code;
    bit  ex_rej;
    bit  ex_ovf;
    code   = model_code(row, col);
    ex_rej = 1'b0;
    ex_ovf = 1'b0;
    if (!m_ready) begin
      if (code == 15) begin
        ex_rej = 1'b1;
      end else if (code <= 9) begin
        if (q.size() < MAXD) q.push_back(code);
        else ex_ovf = 1'b1;
      end else if (code == 10) begin
        if (q.size() > 0) void'(q.pop_back());
      end else begin
        if (q.size() >= MIND) m_ready = 1'b1;
        else begin
          ex_rej = 1'b1;
          q.delete();
        end
      end
    end
    dataReady = 1'b1;
    foundRow  = row;
    foundCol  = col;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("strobe_early", key_strobe, 32'd0);
    end
    tick();
    chk("strobe", key_strobe, 32'd1);
    chk("key_code", key_code, 32'(code));
    chk("reject", reject, 32'(ex_rej));
    chk("overflow", overflow, 32'(ex_ovf));
    chk("pin_valid", pin_valid, 32'(m_ready));
    chk("digit_count", digit_count, 32'(q.size()));
    chk("pin_bcd", pin_bcd, model_bcd());
    dataReady = 1'b0;
    tick();
    chk("strobe_pulse", key_strobe, 32'd0);
    chk("pulses_clear", {reject, overflow}, 32'd0);
    tick();
    tick();
  endtask

  task automatic ack();
    pin_ack = 1'b1;
    tick();
    pin_ack = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0;
      q.delete();
    end
    chk("ack_valid", pin_valid, 32'(m_ready));
    chk("ack_count", digit_count, 32'(q.size()));
    chk("ack_bcd", pin_bcd, model_bcd());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    m_ready = 1'b0;
    chk("rst_outputs", {key_strobe, key_code, digit_count, pin_valid, reject, overflow, timeout}, 32'd0);
    chk("rst_bcd", pin_bcd, 32'd0);
  endtask

  initial begin
    int s0;
    int t0;
    int unsigned r;

    // Reset state
    tick();
    do_reset();

    // 1: 1,2,3,4,# then ack
    press(0, 0); press(0, 1); press(0, 2); press(1, 0);
    press(3, 2);
    chk("t1_bcd", pin_bcd, 32'h1234);
    chk("t1_valid", pin_valid, 32'd1);
    ack();
    chk("t1_ack_count", digit_count, 32'd0);

    // 2: '*' at count 0, then 5,6,*,7,8,9,#
    press(3, 0);
    chk("t2_star_empty", digit_count, 32'd0);
    press(1, 1); press(1, 2); press(3, 0); press(2, 0); press(2, 1); press(2, 2);
    press(3, 2);
    chk("t2_bcd", pin_bcd, 32'h5789);
    chk("t2_valid", pin_valid, 32'd1);
    ack();

    // 3: short PIN rejected
    press(0, 0); press(0, 1); press(3, 2);
    chk("t3_count", digit_count, 32'd0);
    chk("t3_valid", pin_valid, 32'd0);

    // 4: overflow on 5th digit, then invalid row
    press(0, 0); press(0, 1); press(0, 2); press(1, 0); press(1, 1);
    chk("t4_bcd", pin_bcd, 32'h1234);
    press(4, 1);
    chk("t4_bad_code", key_code, 32'd15);
    press(3, 2);
    ack();

    // 5: dataReady held high for 100 cycles yields one key
    s0 = strb_cnt;
    dataReady = 1'b1;
    foundRow  = 32'd0;
    foundCol  = 32'd0;
    for (int k = 0; k < 100; k++) tick();
    dataReady = 1'b0;
    tick(); tick(); tick();
    chk("t5_one_strobe", strb_cnt - s0, 32'd1);
    q.push_back(1);
    press(0, 1);
    chk("t5_two_digits", digit_count, 32'd2);
    do_reset();

`ifdef PIN_TIMEOUT_EN
    // 6: inactivity clears entry after TMO cycles; READY never times out
    t0 = tmo_cnt;
    press(2, 0);
    for (int k = 0; k < 2 * TMO && tmo_cnt == t0; k++) tick();
    chk("t6_tmo_seen", tmo_cnt - t0, 32'd1);
    chk("t6_tmo_delay", last_tmo_cyc - last_strobe_cyc, 32'(TMO));
    chk("t6_tmo_count", digit_count, 32'd0);
    q.delete();
    press(0, 0); press(0, 1); press(0, 2); press(1, 0); press(3, 2);
    t0 = tmo_cnt;
    for (int k = 0; k < 2 * TMO; k++) tick();
    chk("t6_ready_no_tmo", tmo_cnt - t0, 32'd0);
    chk("t6_ready_valid", pin_valid, 32'd1);
    ack();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        ack();
      end else if (r == 1) begin
        if ($urandom_range(0, 1) == 0) press($urandom_range(4, 100), $urandom_range(0, 2));
        else press($urandom_range(0, 3), $urandom_range(3, 50));
      end else begin
        press($urandom_range(0, 3), $urandom_range(0, 2));
      end
    end

`ifndef PIN_TIMEOUT_EN
    chk("timeout_never", tmo_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
